// File: rtl/chunk_scheduler.sv
// Ping-pong chunk sequencer for one compute unit: steers load beats into the free
// bank, launches compute on the full bank and reports job completion.
module chunk_scheduler #(
    parameter int WR_DAT_CYC_NUM   = 4,
    parameter int RD_SPARSEMAP_NUM = 8,
    parameter int CHUNK_CNT_W      = 8,
    localparam int WC_W = $clog2(WR_DAT_CYC_NUM),
    localparam int SM_W = $clog2(RD_SPARSEMAP_NUM)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [CHUNK_CNT_W-1:0] cfg_chunk_num_i,
    input  logic [SM_W-1:0]        cfg_rd_sparsemap_num_i,
    input  logic                   ld_valid_i,
    output logic                   ld_ready_o,
    output logic                   wr_valid_o,
    output logic [WC_W-1:0]        wr_count_o,
    output logic                   wr_sel_o,
    output logic                   rd_sel_o,
    output logic                   run_valid_o,
    output logic                   chunk_start_o,
    output logic [SM_W-1:0]        rd_sparsemap_num_o,
    input  logic                   chunk_end_i,
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} top_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_RUN = 1'b1} rd_state_t;

    top_state_t             top_state_r, top_state_s;
    rd_state_t              rd_state_r, rd_state_s;
    logic [CHUNK_CNT_W-1:0] chunk_num_r, chunk_num_s;
    logic [CHUNK_CNT_W-1:0] loaded_r, loaded_s;
    logic [CHUNK_CNT_W-1:0] finished_r, finished_s;
    logic [SM_W-1:0]        sm_num_r, sm_num_s;
    logic [1:0]             full_r, full_s;
    logic [WC_W-1:0]        wr_count_r, wr_count_s;
    logic                   wr_sel_r, wr_sel_s;
    logic                   rd_sel_r, rd_sel_s;
    logic                   done_r, done_s;

    logic active_s, cfg_fire_s, wr_fire_s, last_beat_s, end_fire_s, last_chunk_s;
    logic ld_ready_s, chunk_start_s;

    // Handshake qualifiers and combinational datapath controls
    always_comb begin
        active_s      = (top_state_r == S_ACTIVE);
        cfg_fire_s    = cfg_valid_i & ~active_s;
        ld_ready_s    = active_s & ~full_r[wr_sel_r] & (loaded_r < chunk_num_r);
        wr_fire_s     = ld_valid_i & ld_ready_s;
        last_beat_s   = wr_fire_s & (wr_count_r == WC_W'(WR_DAT_CYC_NUM - 1));
        chunk_start_s = active_s & (rd_state_r == R_IDLE) & full_r[rd_sel_r];
        // chunk_end only counts while a chunk is actually running
        end_fire_s    = active_s & (rd_state_r == R_RUN) & chunk_end_i;
        last_chunk_s  = end_fire_s & ((finished_r + CHUNK_CNT_W'(1)) == chunk_num_r);
    end

    // Next-state for both FSMs, bank flags and counters
    always_comb begin
        top_state_s = top_state_r;
        rd_state_s  = rd_state_r;
        chunk_num_s = chunk_num_r;
        loaded_s    = loaded_r;
        finished_s  = finished_r;
        sm_num_s    = sm_num_r;
        full_s      = full_r;
        wr_count_s  = wr_count_r;
        wr_sel_s    = wr_sel_r;
        rd_sel_s    = rd_sel_r;
        done_s      = 1'b0;

        if (last_beat_s) begin
            full_s[wr_sel_r] = 1'b1;
            wr_count_s       = '0;
            wr_sel_s         = ~wr_sel_r;
            loaded_s         = loaded_r + CHUNK_CNT_W'(1);
        end else if (wr_fire_s) begin
            wr_count_s = wr_count_r + WC_W'(1);
        end else begin
            wr_count_s = wr_count_r;
        end

        // Release of the running bank may coincide with a fill of the other bank
        if (end_fire_s) begin
            full_s[rd_sel_r] = 1'b0;
            rd_sel_s         = ~rd_sel_r;
            finished_s       = finished_r + CHUNK_CNT_W'(1);
        end else begin
            finished_s = finished_s;
        end

        case (top_state_r)
            S_IDLE: begin
                if (cfg_fire_s) begin
                    if (cfg_chunk_num_i == '0) begin
                        done_s = 1'b1;
                    end else begin
                        top_state_s = S_ACTIVE;
                        chunk_num_s = cfg_chunk_num_i;
                        sm_num_s    = cfg_rd_sparsemap_num_i;
                        loaded_s    = '0;
                        finished_s  = '0;
                    end
                end else begin
                    top_state_s = S_IDLE;
                end
            end
            S_ACTIVE: begin
                if (last_chunk_s) begin
                    top_state_s = S_IDLE;
                    done_s      = 1'b1;
                end else begin
                    top_state_s = S_ACTIVE;
                end
            end
            default: top_state_s = S_IDLE;
        endcase

        case (rd_state_r)
            R_IDLE: begin
                if (chunk_start_s) begin
                    rd_state_s = R_RUN;
                end else begin
                    rd_state_s = R_IDLE;
                end
            end
            R_RUN: begin
                if (end_fire_s) begin
                    rd_state_s = R_IDLE;
                end else begin
                    rd_state_s = R_RUN;
                end
            end
            default: rd_state_s = R_IDLE;
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            top_state_r <= S_IDLE;
            rd_state_r  <= R_IDLE;
            chunk_num_r <= '0;
            loaded_r    <= '0;
            finished_r  <= '0;
            sm_num_r    <= '0;
            full_r      <= 2'b00;
            wr_count_r  <= '0;
            wr_sel_r    <= 1'b0;
            rd_sel_r    <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            top_state_r <= top_state_s;
            rd_state_r  <= rd_state_s;
            chunk_num_r <= chunk_num_s;
            loaded_r    <= loaded_s;
            finished_r  <= finished_s;
            sm_num_r    <= sm_num_s;
            full_r      <= full_s;
            wr_count_r  <= wr_count_s;
            wr_sel_r    <= wr_sel_s;
            rd_sel_r    <= rd_sel_s;
            done_r      <= done_s;
        end
    end

    assign cfg_ready_o        = ~active_s;
    assign ld_ready_o         = ld_ready_s;
    assign wr_valid_o         = wr_fire_s;
    assign wr_count_o         = wr_count_r;
    assign wr_sel_o           = wr_sel_r;
    assign rd_sel_o           = rd_sel_r;
    assign chunk_start_o      = chunk_start_s;
    assign run_valid_o        = chunk_start_s | (rd_state_r == R_RUN);
    assign rd_sparsemap_num_o = sm_num_r;
    assign busy_o             = active_s;
    assign done_o             = done_r;

endmodule

// File: tb/tb_chunk_scheduler.sv
// Randomized bench for chunk_scheduler: a chunk-accounting reference model predicts
// every output each cycle from counts of accepted beats and finished chunks.
module tb_chunk_scheduler;

    localparam int W     = 4;
    localparam int SMN   = 8;
    localparam int CW    = 8;
    localparam int WC_W  = $clog2(W);
    localparam int SM_W  = $clog2(SMN);
    localparam int NCYC  = 6000;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            cfg_valid_i = 1'b0;
    logic            cfg_ready_o;
    logic [CW-1:0]   cfg_chunk_num_i = '0;
    logic [SM_W-1:0] cfg_rd_sparsemap_num_i = '0;
    logic            ld_valid_i = 1'b0;
    logic            ld_ready_o;
    logic            wr_valid_o;
    logic [WC_W-1:0] wr_count_o;
    logic            wr_sel_o;
    logic            rd_sel_o;
    logic            run_valid_o;
    logic            chunk_start_o;
    logic [SM_W-1:0] rd_sparsemap_num_o;
    logic            chunk_end_i = 1'b0;
    logic            busy_o;
    logic            done_o;

    chunk_scheduler #(.WR_DAT_CYC_NUM(W), .RD_SPARSEMAP_NUM(SMN), .CHUNK_CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
        .cfg_chunk_num_i(cfg_chunk_num_i), .cfg_rd_sparsemap_num_i(cfg_rd_sparsemap_num_i),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o),
        .wr_valid_o(wr_valid_o), .wr_count_o(wr_count_o), .wr_sel_o(wr_sel_o),
        .rd_sel_o(rd_sel_o), .run_valid_o(run_valid_o), .chunk_start_o(chunk_start_o),
        .rd_sparsemap_num_o(rd_sparsemap_num_o), .chunk_end_i(chunk_end_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: job described only by beats accepted and chunks finished
    bit m_active, m_run, m_done, m_base;
    int m_chunks, m_sm, m_beats, m_fin;

    task automatic model_reset();
        m_active = 1'b0; m_run = 1'b0; m_done = 1'b0; m_base = 1'b0;
        m_chunks = 0; m_sm = 0; m_beats = 0; m_fin = 0;
    endtask

    task automatic check_and_advance();
        int  loaded;
        bit  e_ld_ready, e_wr_valid, e_start;
        loaded     = m_beats / W;
        e_ld_ready = m_active && (loaded < m_chunks) && ((loaded - m_fin) < 2);
        e_wr_valid = ld_valid_i && e_ld_ready;
        e_start    = m_active && !m_run && (loaded > m_fin);

        check_eq("cfg_ready",   int'(cfg_ready_o),   int'(!m_active));
        check_eq("busy",        int'(busy_o),        int'(m_active));
        check_eq("done",        int'(done_o),        int'(m_done));
        check_eq("ld_ready",    int'(ld_ready_o),    int'(e_ld_ready));
        check_eq("wr_valid",    int'(wr_valid_o),    int'(e_wr_valid));
        check_eq("wr_count",    int'(wr_count_o),    m_beats % W);
        check_eq("wr_sel",      int'(wr_sel_o),      int'(m_base ^ bit'(loaded % 2)));
        check_eq("rd_sel",      int'(rd_sel_o),      int'(m_base ^ bit'(m_fin % 2)));
        check_eq("chunk_start", int'(chunk_start_o), int'(e_start));
        check_eq("run_valid",   int'(run_valid_o),   int'(e_start || m_run));
        check_eq("rd_sm_num",   int'(rd_sparsemap_num_o), m_sm);

        m_done = 1'b0;
        if (rst_i) begin
            model_reset();
        end else if (m_active) begin
            if (e_wr_valid) m_beats++;
            if (m_run) begin
                if (chunk_end_i) begin
                    m_run = 1'b0;
                    m_fin++;
                    if (m_fin == m_chunks) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                        m_base   = m_base ^ bit'(m_chunks % 2);
                        m_beats  = 0;
                        m_fin    = 0;
                    end
                end
            end else if (e_start) begin
                m_run = 1'b1;
            end
        end else if (cfg_valid_i) begin
            if (cfg_chunk_num_i == '0) begin
                m_done = 1'b1;
            end else begin
                m_active = 1'b1;
                m_chunks = int'(cfg_chunk_num_i);
                m_sm     = int'(cfg_rd_sparsemap_num_i);
                m_beats  = 0;
                m_fin    = 0;
                m_run    = 1'b0;
            end
        end
    endtask

    int ld_mode = 0;
    bit toggle = 1'b0;

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc % 250 == 0) ld_mode = $urandom_range(0, 2);
            toggle = ~toggle;
            rst_i = (cyc > 20) && ($urandom_range(0, 499) == 0);
            cfg_valid_i = m_active ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 3) == 0);
            cfg_chunk_num_i = ($urandom_range(0, 4) == 0) ? CW'(0) : CW'($urandom_range(1, 5));
            cfg_rd_sparsemap_num_i = SM_W'($urandom);
            case (ld_mode)
                0:       ld_valid_i = 1'b1;
                1:       ld_valid_i = toggle;
                default: ld_valid_i = ($urandom_range(0, 1) == 1);
            endcase
            chunk_end_i = m_run ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 9) == 0);
            @(negedge clk);
            check_and_advance();
            @(posedge clk);
            #1;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/chunk_scheduler.md
Name: chunk_scheduler

Overview:
- Sequences one compute unit's double-buffered (ping-pong) ifm/filter chunk memories.
- Accepts a job config (chunk count, sparsemap read count). Steers upstream load beats into the free bank: write count, write bank select.
- Launches compute on the full bank (chunk_start, run_valid, read bank select) and frees the bank on chunk_end.
- Reports job completion. Sits between the load DMA/distributor and one compute unit instance.

Parameters:
WR_DAT_CYC_NUM, 4, write beats per chunk per bank (MEM_SIZE/BUS_SIZE); must be >=2
RD_SPARSEMAP_NUM, 8, sparsemap reads per chunk (MEM_SIZE/PREFIX_SUM_SIZE); sets width of rd_sparsemap_num
CHUNK_CNT_W, 8, width of job chunk counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cfg_valid_i  in  1  job config valid
cfg_ready_o  out  1  job config accepted when high with cfg_valid_i
cfg_chunk_num_i  in  CHUNK_CNT_W  chunks in job
cfg_rd_sparsemap_num_i  in  $clog2(RD_SPARSEMAP_NUM)  sparsemap read count for job
ld_valid_i  in  1  upstream beat (ifm+filter together) valid
ld_ready_o  out  1  scheduler can accept beat
wr_valid_o  out  1  drives ifm_wr_valid and filter_wr_valid
wr_count_o  out  $clog2(WR_DAT_CYC_NUM)  beat index within chunk
wr_sel_o  out  1  bank being written
rd_sel_o  out  1  bank being read
run_valid_o  out  1  compute enable
chunk_start_o  out  1  one-cycle chunk launch pulse
rd_sparsemap_num_o  out  $clog2(RD_SPARSEMAP_NUM)  latched config value
chunk_end_i  in  1  compute unit finished current chunk
busy_o  out  1  job active
done_o  out  1  one-cycle job-complete pulse

Behaviour:
- Clock clk_i, one domain. rst_i is synchronous and active-high.
- Reset: all state cleared. wr_count_o=0, wr_sel_o=0, rd_sel_o=0, rd_sparsemap_num_o=0, full[1:0]=0, counters=0. ld_ready_o, wr_valid_o, run_valid_o, chunk_start_o, busy_o, done_o all 0. cfg_ready_o=1. Reset mid-job abandons the job with no done_o.
- Top FSM: IDLE, ACTIVE.
  - IDLE: cfg_ready_o=1.
  - cfg handshake with chunk_num>0: latch chunk_num and rd_sparsemap_num; go to ACTIVE next cycle; busy_o=1.
  - cfg handshake with chunk_num==0: done_o pulses next cycle; stay IDLE.
  - ACTIVE: cfg_ready_o=0; cfg_valid_i is ignored.
- Write side (combinational outputs):
  - ld_ready_o = ACTIVE & ~full[wr_sel_o] & (loaded < chunk_num).
  - wr_valid_o = ld_valid_i & ld_ready_o.
  - wr_count_o and wr_sel_o are registered and valid in the same cycle as wr_valid_o.
- On each accepted beat: wr_count_o increments.
  - At WR_DAT_CYC_NUM-1: wr_count_o wraps to 0, full[wr_sel_o] is set, wr_sel_o toggles, loaded increments. All take effect next cycle.
  - ld_valid_i bubbles hold the count.
- Read FSM: R_IDLE, R_RUN.
  - chunk_start_o = ACTIVE & R_IDLE & full[rd_sel_o] (combinational). The FSM enters R_RUN in that cycle.
  - run_valid_o = chunk_start_o | R_RUN.
  - Earliest chunk_start_o is the cycle after the last beat of that bank is accepted.
- chunk_end_i in R_RUN:
  - full[rd_sel_o] clears, rd_sel_o toggles, finished increments, FSM returns to R_IDLE (next cycle).
  - Next chunk_start_o can fire the following cycle if the other bank is full.
  - If this was chunk chunk_num: top FSM returns to IDLE, busy_o drops, done_o pulses one cycle (all next cycle).
- chunk_end_i outside R_RUN, including the chunk_start_o cycle, is ignored.
- Simultaneous events:
  - A bank fill and the release of the other bank in the same cycle are both applied.
  - A freed bank is writable the cycle after release.
  - The write bank can never be the running bank while full; no write-while-read hazard exists.
- Counters loaded and finished are CHUNK_CNT_W wide and never wrap within a job.

Test Plan:
- Single chunk: reset, cfg chunk_num=1, rd_sparsemap_num=3, 4 continuous beats -> wr_count 0,1,2,3 on wr_sel=0. chunk_start_o 1 cycle after the 4th beat, run_valid_o high until chunk_end_i (driven 10 cycles later). done_o pulses 1 cycle after chunk_end_i. rd_sparsemap_num_o=3.
- Ping-pong: chunk_num=3, ld_valid_i held high:
  - Beats 1-4 go to bank0, beats 5-8 to bank1, then ld_ready_o=0.
  - On chunk_end_i for bank0: rd_sel_o=1, chunk_start_o fires next cycle, and bank0 refills (beats 9-12).
  - done_o after the 3rd chunk_end_i; ld_ready_o never rises after 12 beats.
- Bubbles: ld_valid_i toggling 1,0,1,0 -> wr_count_o advances only on accepted beats; full set only after 4 accepted beats.
- Zero-length job: cfg chunk_num=0 -> done_o next cycle, busy_o stays 0, ld_ready_o stays 0.
- Spurious end and config: chunk_end_i pulsed in R_IDLE and cfg_valid_i pulsed during ACTIVE -> no state change, no done_o.
- Reset mid-run: assert rst_i during R_RUN of chunk 2 of 3 -> next cycle all outputs equal reset values, cfg_ready_o=1. A new job starts cleanly on bank0.
